stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter MIN_MAX, default 59: highest minutes value; legal range 1..99.
REQ-002 clk  input  1  system clock, 100 MHz.
REQ-003 rst  input  1  reset; one clock; synchronous, active-high.
REQ-004 tick_1hz  input  1  one-cycle enable pulse, once per second, from the clk1hz divider stage.
REQ-005 tick_2hz  input  1  one-cycle enable pulse, twice per second, from the same divider stage.
REQ-006 pause_btn  input  1  debounced one-cycle pulse; toggles run/pause.
REQ-007 adj  input  1  level; 1 = adjust mode.
REQ-008 sel  input  1  level; adjust field select, 0 = minutes, 1 = seconds.
REQ-009 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits of MM:SS, registered.
REQ-010 running  output  1  1 when FSM is in RUN.
REQ-011 blink  output  1  adjust-mode blink phase for the display driver.
REQ-012 wrap  output  1  one-cycle pulse when the count rolls from MIN_MAX:59 to 00:00.

Function
REQ-013 FSM states: PAUSED and RUN; all outputs registered; no combinational input-to-output path.
REQ-014 PAUSED -> RUN and RUN -> PAUSED on pause_btn=1 while adj=0; pause_btn is ignored while adj=1.
REQ-015 In RUN with adj=0, each tick_1hz advances the count by one second; digits update on the clock edge after the tick cycle (latency 1).
REQ-016 Seconds: sec_ones 9->0 carries into sec_tens; seconds 59->00 carries into minutes.
REQ-017 Minutes: min_ones 9->0 carries into min_tens; the next count after MIN_MAX:59 is 00:00 with wrap=1 for exactly that cycle.
REQ-018 Every digit stays a legal BCD value (0..9, tens of seconds 0..5); no digit ever holds A..F.
REQ-019 In PAUSED, tick_1hz has no effect on the digits.
REQ-020 Simultaneous tick_1hz and pause_btn in RUN: the count advances and the state goes to PAUSED in the same edge.
REQ-021 Simultaneous tick_1hz and pause_btn in PAUSED: no count; the state goes to RUN.
REQ-022 adj=1 inhibits tick_1hz counting in both states; the FSM state is held.
REQ-023 Each tick_2hz with adj=1 increments the selected field by one with no carry into the other field.
REQ-024 In adjust mode, seconds wrap 59->00, minutes wrap MIN_MAX->00, and wrap stays 0.
REQ-025 If tick_1hz and tick_2hz coincide while adj=1, only the adjust action occurs.
REQ-026 blink toggles on each tick_2hz while adj=1 and is forced to 0 on the edge after adj=0 is sampled.
REQ-027 A sel change mid-adjust takes effect on the next tick_2hz; digits are not altered.

Reset
REQ-028 rst=1 at a clock edge sets state=PAUSED, all digits=0, running=0, blink=0, wrap=0.
REQ-029 rst overrides every other input in the same cycle, including mid-count, mid-wrap and mid-adjust.
REQ-030 After rst deasserts, the first pause_btn starts counting from 00:00.

Structure
REQ-031 A shared package stopwatch_pkg holds the FSM state encoding, the constants SEC_MAX=59 and BCD_MAX=9, and the MIN_MAX default.
REQ-032 One sub-module, bcd_mod_counter, is used: a two-digit BCD counter with parameterised maximum, inc input, clr input, and carry-out pulse.
REQ-033 stopwatch_core instantiates two bcd_mod_counter instances (seconds, minutes) plus the FSM and blink/wrap logic.

Verification
REQ-034 Reset then pause_btn, then 61 tick_1hz pulses -> digits 01:01, running=1.
REQ-035 Preload 59:59 via adjust, adj=0, RUN, one tick_1hz -> 00:00 and wrap=1 for exactly one cycle.
REQ-036 RUN, tick_1hz coincident with pause_btn at 00:05 -> 00:06, running=0; three further ticks -> still 00:06.
REQ-037 adj=1, sel=1, 62 tick_2hz from 00:00 -> 00:02 with no minute carry; blink toggles 62 times, then 0 after adj=0.
REQ-038 adj=1, sel=0, MIN_MAX=59, 60 tick_2hz from 00:00 -> 00:00, wrap never asserted; coincident tick_1hz never counts.
REQ-039 rst asserted during RUN at 12:34 -> next edge 00:00, running=0, blink=0; a BCD-legality check runs on every cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_pkg : shared FSM encoding and counting limits for the      |
// |                 MM:SS stopwatch.                                     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

    typedef enum logic [0:0] {
        ST_PAUSED = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    localparam int SEC_MAX         = 59;
    localparam int BCD_MAX         = 9;
    localparam int MIN_MAX_DEFAULT = 59;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_mod_counter : two-digit BCD counter, 00..MAX, with clear and a   |
// |                   same-cycle carry-out when an increment wraps.      |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       carry_o
);

    localparam logic [3:0] MAX_TENS  = 4'(MAX / 10);
    localparam logic [3:0] MAX_ONES  = 4'(MAX % 10);
    localparam logic [3:0] DIGIT_TOP = 4'(BCD_MAX);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       at_max;

    assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc_i) begin
            if (at_max) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == DIGIT_TOP) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    // Carry is combinational so the next field can increment on the same edge.
    assign carry_o = inc_i && at_max && !clr_i;
    assign tens_o  = tens_q;
    assign ones_o  = ones_q;

endmodule : bcd_mod_counter
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_core : MM:SS BCD stopwatch with run/pause FSM, per-field   |
// |                  adjust mode, blink phase and roll-over pulse.       |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = MIN_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blink,
    output logic       wrap
);

    state_e state_q, state_d;
    logic   blink_q, blink_d;
    logic   wrap_q, wrap_d;
    logic   count_en, sec_inc, min_inc, sec_carry, min_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PAUSED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!adj && pause_btn) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    always_comb begin
        running = (state_q == ST_RUN);
    end

    // Adjust mode steers tick_2hz to one field only; real-time counting is off.
    assign count_en = !adj && tick_1hz && (state_q == ST_RUN);
    assign sec_inc  = adj ? (tick_2hz && sel)  : count_en;
    assign min_inc  = adj ? (tick_2hz && !sel) : (count_en && sec_carry);

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (sec_inc),
        .clr_i   (1'b0),
        .tens_o  (sec_tens),
        .ones_o  (sec_ones),
        .carry_o (sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (min_inc),
        .clr_i   (1'b0),
        .tens_o  (min_tens),
        .ones_o  (min_ones),
        .carry_o (min_carry)
    );

    always_comb begin
        blink_d = 1'b0;
        if (adj) begin
            blink_d = tick_2hz ? !blink_q : blink_q;
        end
        wrap_d = !adj && min_carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            blink_q <= blink_d;
            wrap_q  <= wrap_d;
        end
    end

    assign blink = blink_q;
    assign wrap  = wrap_q;

endmodule : stopwatch_core
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stopwatch_core : scoreboard bench for stopwatch_core, directed    |
// |                     scenarios followed by randomized traffic.        |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_stopwatch_core;

    localparam int MIN_MAX = 59;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, pause_btn = 1'b0;
    logic       adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, blink, wrap;

    always #5 clk = ~clk;

    stopwatch_core #(.MIN_MAX(MIN_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .pause_btn (pause_btn),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .blink     (blink),
        .wrap      (wrap)
    );

    typedef struct packed {
        logic [3:0] mt, mo, st, so;
        logic       run, blk, wr;
    } resp_t;

    resp_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Reference model: whole minutes/seconds as integers, plus run/blink/wrap.
    int m_mm = 0, m_ss = 0;
    bit m_run = 0, m_blink = 0, m_wrap = 0;

    function automatic resp_t model_resp();
        resp_t r;
        r.mt  = 4'(m_mm / 10);
        r.mo  = 4'(m_mm % 10);
        r.st  = 4'(m_ss / 10);
        r.so  = 4'(m_ss % 10);
        r.run = m_run;
        r.blk = m_blink;
        r.wr  = m_wrap;
        return r;
    endfunction

    task automatic model_update(input bit r, t1, t2, pb, a, s);
        if (r) begin
            m_mm = 0; m_ss = 0; m_run = 0; m_blink = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (a) begin
                if (t2) begin
                    if (s) m_ss = (m_ss + 1) % 60;
                    else   m_mm = (m_mm + 1) % (MIN_MAX + 1);
                    m_blink = !m_blink;
                end
            end else begin
                m_blink = 0;
                if (m_run && t1) begin
                    int total;
                    total = m_mm * 60 + m_ss + 1;
                    if (total == (MIN_MAX + 1) * 60) begin
                        total  = 0;
                        m_wrap = 1;
                    end
                    m_mm = total / 60;
                    m_ss = total % 60;
                end
                if (pb) m_run = !m_run;
            end
        end
    endtask

    // One clock of stimulus: drive on the falling edge, queue the expected response.
    task automatic step(input bit r, t1, t2, pb, a, s);
        @(negedge clk);
        rst = r; tick_1hz = t1; tick_2hz = t2; pause_btn = pb; adj = a; sel = s;
        model_update(r, t1, t2, pb, a, s);
        exp_q.push_back(model_resp());
    endtask

    task automatic idle(input int n, input bit a, s);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, a, s);
    endtask

    // Absolute check against hand-derived values, after the edge of the last step.
    task automatic check_dut(input string name, input int mm, ss, input bit run, blk, wr);
        @(posedge clk);
        #2;
        vectors++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)}
            || running !== run || blink !== blk || wrap !== wr) begin
            miscompares++;
            $display("FAIL %s: got %0d%0d:%0d%0d run=%b blink=%b wrap=%b, expected %02d:%02d run=%b blink=%b wrap=%b",
                     name, min_tens, min_ones, sec_tens, sec_ones, running, blink, wrap, mm, ss, run, blk, wr);
        end
    endtask

    // Monitor: every clock the DUT presents a new registered response.
    initial begin
        resp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {min_tens, min_ones, sec_tens, sec_ones, running, blink, wrap};
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard @%0t: got %0d%0d:%0d%0d run=%b blink=%b wrap=%b, expected %0d%0d:%0d%0d run=%b blink=%b wrap=%b",
                             $time, g.mt, g.mo, g.st, g.so, g.run, g.blk, g.wr,
                             e.mt, e.mo, e.st, e.so, e.run, e.blk, e.wr);
                end
                vectors++;
                if (sec_tens > 4'd5 || sec_ones > 4'd9 || min_tens > 4'd9 || min_ones > 4'd9) begin
                    miscompares++;
                    $display("FAIL bcd_legal @%0t: got %h%h:%h%h, required every digit decimal and sec_tens<=5",
                             $time, min_tens, min_ones, sec_tens, sec_ones);
                end
            end
        end
    end

    initial begin
        bit a_lvl, s_lvl;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        check_dut("reset", 0, 0, 0, 0, 0);

        // Start, then 61 seconds
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 61; i++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        check_dut("run_61s", 1, 1, 1, 0, 0);

        // Preload 59:59 via adjust, then roll over
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        check_dut("preload_5959", 59, 59, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check_dut("wrap_pulse", 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        check_dut("wrap_one_cycle", 0, 0, 1, 0, 0);

        // Tick coincident with pause at 00:05
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        check_dut("tick_and_pause", 0, 6, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        check_dut("paused_ticks", 0, 6, 0, 0, 0);

        // Seconds adjust: 62 steps, no minute carry, blink back to 0 after exit
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 62; i++) step(0, 0, 1, 0, 1, 1);
        check_dut("adj_sec_62", 0, 2, 0, 0, 0);
        step(0, 0, 1, 0, 1, 1);
        check_dut("adj_blink_odd", 0, 3, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        check_dut("blink_clear", 0, 3, 0, 0, 0);

        // Minutes adjust full lap while running with coincident 1 Hz ticks
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 60; i++) step(0, 1, 1, 1, 1, 0);
        check_dut("adj_min_lap", 0, 0, 1, 0, 0);

        // Reset during RUN at 12:34
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 34; i++) step(0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check_dut("preload_1234", 12, 34, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        check_dut("rst_in_run", 0, 0, 0, 0, 0);

        // Reset mid-adjust with blink high
        step(0, 0, 1, 0, 1, 1);
        step(1, 0, 1, 0, 1, 1);
        check_dut("rst_in_adj", 0, 0, 0, 0, 0);

        // Randomized traffic
        a_lvl = 0;
        s_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) a_lvl = !a_lvl;
            if ($urandom_range(0, 19) == 0) s_lvl = !s_lvl;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 a_lvl, s_lvl);
        end

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_stopwatch_core
`default_nettype wire
